// File: rtl/bus_timer_responder_pkg.sv
// bus_timer_responder_pkg: register offsets, CTRL field positions and timer states
package bus_timer_responder_pkg;
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;
  localparam int CTRL_EN           = 0;
  localparam int CTRL_AUTO_RELOAD  = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;
  localparam int STATUS_MATCH      = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXPIRED} state_e;
endpackage

// File: rtl/bus_timer_responder_prescaler.sv
// timer_prescaler: issues a one-cycle tick every prescale+1 enabled cycles
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] prescale,
  output logic       tick
);
  logic [7:0] pcnt_q, pcnt_d;
  always_comb begin
    tick   = en && (pcnt_q == prescale);
    pcnt_d = (en && !tick) ? pcnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst) pcnt_q <= 8'd0;
    else pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/bus_timer_responder.sv
// bus_timer_responder: 4-word memory-mapped timer with compare match, auto-reload and irq
module bus_timer_responder
  import bus_timer_responder_pkg::*;
#(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32,
  parameter logic [A_SIZE-1:0] BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [A_SIZE-1:0] address,
  input  logic [D_SIZE-1:0] data_input,
  output logic [D_SIZE-1:0] data_output,
  output logic              hit,
  output logic              irq
);
  logic en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d, irq_q, irq_d;
  logic [7:0] pre_q, pre_d;
  logic [D_SIZE-1:0] count_q, count_d, cmp_q, cmp_d, ctrl_rd;
  state_e state_q, state_d;
  logic tick, step, fire, wr;
  logic [1:0] off;

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .prescale (pre_q),
    .tick     (tick)
  );

  always_comb begin
    hit  = address[A_SIZE-1:2] == BASE[A_SIZE-1:2];
    off  = address[1:0];
    wr   = write && hit;
    step = (state_q == ST_RUN) && tick;
    fire = step && (count_q == cmp_q);
    en_d = en_q;
    ar_d = ar_q;
    ie_d = ie_q;
    pre_d = pre_q;
    cmp_d = cmp_q;
    state_d = state_q;
    irq_d = match_q && ie_q;
    // a hardware set is applied after the software clear so it wins
    match_d = (wr && off == OFF_STATUS && data_input[STATUS_MATCH]) ? 1'b0 : match_q;
    count_d = step ? count_q + D_SIZE'(1) : count_q;
    if (fire) begin
      match_d = 1'b1;
      count_d = ar_q ? '0 : count_q;
      en_d    = ar_q;
      state_d = ar_q ? ST_RUN : ST_EXPIRED;
    end
    if (wr && off == OFF_CTRL) begin
      en_d    = data_input[CTRL_EN];
      ar_d    = data_input[CTRL_AUTO_RELOAD];
      ie_d    = data_input[CTRL_IRQ_EN];
      pre_d   = data_input[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
      state_d = data_input[CTRL_EN] ? ST_RUN : ST_IDLE;
    end
    if (wr && off == OFF_COUNT) count_d = data_input;
    if (wr && off == OFF_COMPARE) cmp_d = data_input;
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_AUTO_RELOAD] = ar_q;
    ctrl_rd[CTRL_IRQ_EN] = ie_q;
    ctrl_rd[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = pre_q;
    data_output = !(read && hit) ? '0 :
                  off == OFF_CTRL    ? ctrl_rd :
                  off == OFF_COUNT   ? count_q :
                  off == OFF_COMPARE ? cmp_q : D_SIZE'(match_q);
    irq = irq_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      pre_q   <= 8'd0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= irq_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_bus_timer_responder.sv
// tb_bus_timer_responder: directed vectors plus a register-level model checked every cycle
module tb_bus_timer_responder;
  localparam logic [9:0] BASE = 10'h3F0;
  logic clk, rst, read, write, hit, irq;
  logic [9:0] address;
  logic [31:0] data_input, data_output;
  int n_pass = 0, n_chk = 0;
  bit chk_on = 0;

  bus_timer_responder #(.A_SIZE(10), .D_SIZE(32), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .data_input(data_input), .data_output(data_output), .hit(hit), .irq(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // model: timer runs whenever en is set; prescaler as elapsed-cycle phase
  bit m_en, m_ar, m_ie, m_match, m_irq, sel, tk, fire;
  bit [7:0] m_pre, m_ph;
  bit [31:0] m_cnt, m_cmp;
  always @(posedge clk) begin
    if (!rst) begin
      {m_en, m_ar, m_ie, m_match, m_irq} = '0;
      m_pre = 0; m_ph = 0; m_cnt = 0; m_cmp = 0;
    end else begin
      sel  = write && address[9:2] == BASE[9:2];
      tk   = m_en && m_ph == m_pre;
      fire = tk && m_cnt == m_cmp;
      m_irq = m_match && m_ie;
      m_ph = (m_en && !tk) ? m_ph + 1 : 0;
      m_match = fire || (m_match && !(sel && address[1:0] == 3 && data_input[0]));
      if (sel && address[1:0] == 1) m_cnt = data_input;
      else if (fire) m_cnt = m_ar ? 0 : m_cnt;
      else if (tk) m_cnt = m_cnt + 1;
      if (fire && !m_ar) m_en = 0;
      if (sel && address[1:0] == 0) begin
        m_en = data_input[0]; m_ar = data_input[1]; m_ie = data_input[2]; m_pre = data_input[15:8];
      end
      if (sel && address[1:0] == 2) m_cmp = data_input;
    end
  end

  function automatic logic [31:0] exp_dout();
    if (!(read && address[9:2] == BASE[9:2])) return 0;
    case (address[1:0])
      2'd0: return {16'd0, m_pre, 5'd0, m_ie, m_ar, m_en};
      2'd1: return m_cnt;
      2'd2: return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (chk_on) begin
    check("model_dout", data_output, exp_dout());
    check("model_hit", {31'd0, hit}, {31'd0, address[9:2] == BASE[9:2]});
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    write = 1; address = a; data_input = d;
    cyc();
    write = 0;
  endtask

  task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] exp);
    read = 1; address = a;
    #1;
    check(name, data_output, exp);
  endtask

  initial begin
    rst = 0; read = 0; write = 0; address = 0; data_input = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1; chk_on = 1;
    for (int i = 0; i < 4; i++) rd_chk("reset_reg", BASE + 10'(i), 0);
    check("reset_irq", {31'd0, irq}, 0);
    address = BASE; #1; check("hit_base", {31'd0, hit}, 1);
    address = BASE + 10'd4; #1; check("hit_above", {31'd0, hit}, 0);
    // one-shot run
    wr(BASE + 2, 5);
    wr(BASE + 0, 32'h0005);
    for (int k = 0; k <= 5; k++) begin
      rd_chk("oneshot_count", BASE + 1, k);
      cyc();
    end
    rd_chk("oneshot_match", BASE + 3, 1);
    check("oneshot_irq_lag", {31'd0, irq}, 0);
    rd_chk("oneshot_ctrl", BASE + 0, 32'h0004);
    cyc();
    check("oneshot_irq", {31'd0, irq}, 1);
    rd_chk("oneshot_hold", BASE + 1, 5);
    wr(BASE + 0, 0);
    wr(BASE + 3, 1);
    rd_chk("w1c_clear", BASE + 3, 0);
    // auto-reload with prescale 3
    wr(BASE + 1, 0);
    wr(BASE + 2, 2);
    wr(BASE + 0, 32'h0303);
    for (int j = 0; j < 24; j++) begin
      rd_chk("reload_count", BASE + 1, (j / 4) % 3);
      rd_chk("reload_match", BASE + 3, j >= 12);
      cyc();
    end
    rd_chk("reload_ctrl", BASE + 0, 32'h0303);
    cyc(); cyc(); cyc();
    wr(BASE + 1, 32'h10);
    rd_chk("count_write_on_tick", BASE + 1, 32'h10);
    // software clear and match set on the same edge
    wr(BASE + 0, 0);
    wr(BASE + 3, 1);
    wr(BASE + 1, 0);
    wr(BASE + 2, 0);
    wr(BASE + 0, 32'h0003);
    rd_chk("pre_match", BASE + 3, 0);
    wr(BASE + 3, 1);
    rd_chk("set_beats_w1c", BASE + 3, 1);
    wr(BASE + 0, 0);
    rd_chk("match_on_disable", BASE + 3, 1);
    rd_chk("ctrl_disabled", BASE + 0, 0);
    wr(BASE + 3, 1);
    // bus isolation
    wr(BASE + 2, 32'h55);
    wr(BASE - 10'd1, 32'hDEADBEEF);
    wr(BASE + 10'd4, 32'hDEADBEEF);
    rd_chk("iso_below_dout", BASE - 10'd1, 0);
    check("iso_below_hit", {31'd0, hit}, 0);
    rd_chk("iso_above_dout", BASE + 10'd4, 0);
    check("iso_above_hit", {31'd0, hit}, 0);
    rd_chk("iso_compare", BASE + 2, 32'h55);
    rd_chk("iso_ctrl", BASE + 0, 0);
    rd_chk("iso_status", BASE + 3, 0);
    // reset in the middle of a count
    wr(BASE + 1, 0);
    wr(BASE + 2, 100);
    wr(BASE + 0, 32'h0005);
    repeat (37) cyc();
    rd_chk("pre_reset_count", BASE + 1, 37);
    rst = 0;
    cyc();
    rst = 1;
    for (int i = 0; i < 4; i++) rd_chk("midreset_reg", BASE + 10'(i), 0);
    check("midreset_irq", {31'd0, irq}, 0);
    repeat (20) cyc();
    rd_chk("post_reset_status", BASE + 3, 0);
    rd_chk("post_reset_count", BASE + 1, 0);
    check("post_reset_irq", {31'd0, irq}, 0);
    read = 0;
    cyc();
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_timer_responder.md
Name: bus_timer_responder

Overview:
- Memory-mapped timer/compare peripheral on the core data bus (read, write, address, data_in, data_out).
- It is the responder side of that bus, sitting beside memory inside the RISC top.
- It claims a 4-word address window at BASE and returns read data through a gated output, so the top can OR it with the memory read data.
- A prescaled counter, a compare match, an auto-reload option and an interrupt line provide the sequential behaviour.

Parameters:
- A_SIZE, 10, bus address width.
- D_SIZE, 32, bus data width; also the width of COUNT and COMPARE.
- BASE, 10'h3F0, window base address; must be 4-word aligned (BASE[1:0]==0).

Ports:
- clk input 1: single clock; all state updates on its rising edge.
- rst input 1: reset, synchronous, active-low.
- read input 1: bus read strobe from the core.
- write input 1: bus write strobe from the core.
- address input A_SIZE: bus word address.
- data_input input D_SIZE: write data from the core.
- data_output output D_SIZE: read data; all zeros when not selected.
- hit output 1: high when address[A_SIZE-1:2]==BASE[A_SIZE-1:2]; combinational.
- irq output 1: registered; equals STATUS.match AND CTRL.irq_en.

Behaviour:
- Reset (rst==0 at a clk edge): CTRL, COUNT, COMPARE, STATUS and the prescaler count all go to 0; state goes to IDLE; irq=0.
  - data_output is 0 while read is low, so it reads 0 after reset.
  - Reset asserted mid-count aborts the count immediately; no match is flagged.
- Register map, word offset address[1:0]:
  - 0 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en, bits[15:8] prescale; other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 match; write-1-to-clear; other bits read 0, and writes to them are ignored.
- Reads:
  - data_output = selected register when read && hit; otherwise 0. Combinational, zero latency.
  - A read has no side effects.
- Writes:
  - A write takes effect at the clk edge where write && hit.
  - read and write in the same cycle: data_output shows the pre-write value.
  - Accesses outside the window are ignored.
- Prescaler:
  - While en==1, the 8-bit prescaler counter pcnt increments every cycle.
  - When pcnt==prescale, a one-cycle tick is issued and pcnt returns to 0. prescale=0 therefore ticks every cycle.
  - pcnt is cleared whenever en==0.
- State machine:
  - IDLE: en==0; COUNT holds. A write setting en moves to RUN on the next edge.
  - RUN, on tick:
    - If COUNT==COMPARE: set STATUS.match. If auto_reload, COUNT<=0 and stay in RUN; else go to EXPIRED and clear CTRL.en.
    - Otherwise: COUNT<=COUNT+1, wrapping from 2^D_SIZE-1 to 0 with no flag.
  - EXPIRED: COUNT holds its match value. Software re-enabling en moves to RUN.
  - A write of en=0 from any state goes to IDLE.
- Simultaneous events:
  - Bus write to COUNT on a tick cycle: the written value wins and no increment occurs that cycle. The compare uses the old COUNT.
  - Bus write to COMPARE on a tick cycle: the compare uses the old COMPARE.
  - Hardware match set and software W1C on the same cycle: set wins, match stays 1.
  - A CTRL write that clears en on a match cycle: the match is still flagged, and the state goes to IDLE.
- irq: updated one cycle after STATUS/CTRL change; level-held until match is cleared or irq_en=0.

Decomposition:
- Shared package:
  - Register offset constants (CTRL=0, COUNT=1, COMPARE=2, STATUS=3).
  - CTRL bit positions (EN=0, AUTO_RELOAD=1, IRQ_EN=2, PRESCALE_LSB=8, PRESCALE_MSB=15).
  - State encoding (IDLE, RUN, EXPIRED).
- One sub-module, timer_prescaler: en, prescale[7:0] in; tick out; owns pcnt.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, release, read offsets 0..3 -> data_output 0 for each; irq=0; hit=1 at BASE, hit=0 at BASE+4.
2. One-shot run:
   - Stimulus: COMPARE=5, CTRL=0x0005 (en, irq_en, prescale 0).
   - Response: COUNT steps 0..5 on consecutive cycles; match=1 at the tick where COUNT==5; irq=1 one cycle later; CTRL reads 0x0004; COUNT holds 5.
3. Auto-reload with prescale:
   - Stimulus: COMPARE=2, CTRL=0x0303 (prescale 3).
   - Response: COUNT advances every 4 cycles, 0,1,2,0,1,2; match set at first wrap; state stays RUN.
4. Simultaneous events:
   - Write COUNT=0x10 on a tick cycle -> COUNT reads 0x10 next cycle, not old+1.
   - Write STATUS=1 on a match cycle -> match remains 1.
5. Bus isolation: write 0xDEADBEEF to BASE-1 and BASE+4 -> no register changes; data_output=0 and hit=0 for those reads.
6. Reset mid-operation: run with COMPARE=100, assert rst=0 at COUNT=37 -> next cycle all registers read 0, irq=0, state IDLE; no spurious match after release.
